// File: rtl/input_skew_pkg.sv
// Shared types and helpers for the input_skew block.
//   state_t      : tile-tracking FSM states.
//   cnt_width()  : width of the drain counter for a given lane count.
package input_skew_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/input_skew_if.sv
// Handshake/bus bundle between the row FIFO, input_skew and the array.
//   data_i/valid_i/last_i : row from FIFO (lane k at [k*WIDTH_P +: WIDTH_P])
//   ready_o               : block accepts a row this cycle
//   data_o/valid_o        : skewed per-lane data/valid to the array
//   done_o                : pulse when the last tile row leaves lane LANES_P-1
//   busy_o                : any lane valid or tile in progress
// Modports: slave = input_skew side, master = FIFO/array side.
interface input_skew_if #(
  parameter int LANES_P = 4,
  parameter int WIDTH_P = 8
);
  logic [LANES_P*WIDTH_P-1:0] data_i;
  logic                       valid_i;
  logic                       last_i;
  logic                       ready_o;
  logic [LANES_P*WIDTH_P-1:0] data_o;
  logic [LANES_P-1:0]         valid_o;
  logic                       done_o;
  logic                       busy_o;

  modport slave (
    input  data_i, valid_i, last_i,
    output ready_o, data_o, valid_o, done_o, busy_o
  );

  modport master (
    output data_i, valid_i, last_i,
    input  ready_o, data_o, valid_o, done_o, busy_o
  );
endinterface

// File: rtl/input_skew_lane.sv
// skew_lane: one valid+data shift chain of DEPTH_P stages, shifting every
// cycle. Synchronous active-high reset clears valid and data.
// Optional macro INPUT_SKEW_ZERO_FILL_EN: data of an invalid stage is forced
// to zero; otherwise data stages only load when a valid bit shifts in and
// hold their value across bubbles.
//   clk, rst               : clock, reset
//   shift_valid/shift_data : stage-0 input
//   tail_valid/tail_data   : last stage output
module skew_lane #(
  parameter int DEPTH_P = 1,
  parameter int WIDTH_P = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_valid,
  input  logic [WIDTH_P-1:0] shift_data,
  output logic               tail_valid,
  output logic [WIDTH_P-1:0] tail_data
);

  logic [DEPTH_P-1:0] vld;
  logic [WIDTH_P-1:0] dat [DEPTH_P];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int unsigned i = 0; i < DEPTH_P; i++) dat[i] <= '0;
    end else begin
      vld[0] <= shift_valid;
      for (int unsigned i = 1; i < DEPTH_P; i++) vld[i] <= vld[i-1];
`ifdef INPUT_SKEW_ZERO_FILL_EN
      dat[0] <= shift_valid ? shift_data : '0;
      for (int unsigned i = 1; i < DEPTH_P; i++)
        dat[i] <= vld[i-1] ? dat[i-1] : '0;
`else
      if (shift_valid) dat[0] <= shift_data;
      for (int unsigned i = 1; i < DEPTH_P; i++)
        if (vld[i-1]) dat[i] <= dat[i-1];
`endif
    end
  end

  assign tail_valid = vld[DEPTH_P-1];
  assign tail_data  = dat[DEPTH_P-1];

endmodule

// File: rtl/input_skew.sv
// input_skew: pops one LANES_P-wide row per handshake from the row FIFO and
// presents it diagonally to the systolic array (lane k at acceptance+k+1).
// After the last row of a tile it blocks upstream for LANES_P-1 cycles while
// the row drains, then pulses done_o.
// Ports: clk_i, rst_i (sync, active-high), bus (input_skew_if.slave).
// Optional macro INPUT_SKEW_ZERO_FILL_EN: zero data on invalid lane slots.
module input_skew
  import input_skew_pkg::*;
#(
  parameter int LANES_P = 4,
  parameter int WIDTH_P = 8
) (
  input logic          clk_i,
  input logic          rst_i,
  input_skew_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(LANES_P);

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic                       accept;
  logic [LANES_P-1:0]         tag;
  logic [LANES_P-1:0]         lane_valid;
  logic [LANES_P*WIDTH_P-1:0] lane_data;

  assign bus.ready_o = (state != DRAIN) && !rst_i;
  assign accept      = bus.valid_i && bus.ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, STREAM: begin
          if (accept) begin
            if (bus.last_i) begin
              state <= DRAIN;
              cnt   <= CNT_W'(LANES_P - 1);
            end else begin
              state <= STREAM;
            end
          end
        end
        DRAIN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Last-row tag travels alongside lane LANES_P-1 (same depth), so its tail
  // lines up with that lane presenting the final row.
  always_ff @(posedge clk_i) begin
    if (rst_i) tag <= '0;
    else       tag <= {tag[LANES_P-2:0], accept && bus.last_i};
  end

  for (genvar k = 0; k < LANES_P; k++) begin : g_lane
    skew_lane #(
      .DEPTH_P(k + 1),
      .WIDTH_P(WIDTH_P)
    ) u_lane (
      .clk        (clk_i),
      .rst        (rst_i),
      .shift_valid(accept),
      .shift_data (bus.data_i[k*WIDTH_P +: WIDTH_P]),
      .tail_valid (lane_valid[k]),
      .tail_data  (lane_data[k*WIDTH_P +: WIDTH_P])
    );
  end

  assign bus.valid_o = lane_valid;
  assign bus.data_o  = lane_data;
  assign bus.done_o  = tag[LANES_P-1];
  assign bus.busy_o  = (|lane_valid) || (state != IDLE);

endmodule
